// File: rtl/deserializer_if.sv
// Word-side bundle of the UART deserializer: the serial line in, the assembled
// word and its status strobes out.
interface deserializer_if #(
  parameter int BYTES = 4
);
  logic               rx_wire_in;
  logic [8*BYTES-1:0] data_out;
  logic               valid_out;
  logic               busy_out;
  logic               frame_err_out;
  logic               timeout_out;

  // master: the deserializer itself; slave: the line driver / word consumer
  modport master (
    input  rx_wire_in,
    output data_out, valid_out, busy_out, frame_err_out, timeout_out
  );
  modport slave (
    output rx_wire_in,
    input  data_out, valid_out, busy_out, frame_err_out, timeout_out
  );
endinterface

// File: rtl/deserializer.sv
// 8N1 UART receiver that packs BYTES consecutive bytes (byte 0 in bits [7:0])
// into one word, with framing-error and inter-byte timeout reporting.
module deserializer #(
  parameter int BYTES            = 4,
  parameter int BAUD_RATE        = 9600,
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int TIMEOUT_BITS     = 20
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  deserializer_if.master bus
);
  localparam int PERIOD   = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int HALF     = PERIOD / 2;
  localparam int CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TO_LIMIT = TIMEOUT_BITS * PERIOD;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam int IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WORD_W   = 8 * BYTES;

  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_M1     = TO_W'(TO_LIMIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t            state_reg, state_next;
  logic              rx_meta_reg, rxs_reg;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [2:0]        bit_reg, bit_next;
  logic [7:0]        shift_reg, shift_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [WORD_W-1:0] word_reg, word_next;
  logic [WORD_W-1:0] data_reg, data_next;
  logic [TO_W-1:0]   to_reg, to_next;
  logic              valid_reg, valid_next;
  logic              busy_reg, busy_next;
  logic              ferr_reg, ferr_next;
  logic              tout_reg, tout_next;
  logic [BYTES-1:0]  lane_sel;

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      assign lane_sel[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      rx_meta_reg <= 1'b1;
      rxs_reg     <= 1'b1;
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      idx_reg     <= '0;
      word_reg    <= '0;
      data_reg    <= '0;
      to_reg      <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      tout_reg    <= 1'b0;
    end else begin
      rx_meta_reg <= bus.rx_wire_in;
      rxs_reg     <= rx_meta_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      idx_reg     <= idx_next;
      word_reg    <= word_next;
      data_reg    <= data_next;
      to_reg      <= to_next;
      valid_reg   <= valid_next;
      busy_reg    <= busy_next;
      ferr_reg    <= ferr_next;
      tout_reg    <= tout_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    word_next  = word_reg;
    data_next  = data_reg;
    to_next    = to_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    tout_next  = 1'b0;
    busy_next  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (!rxs_reg) begin
          state_next = S_START;
          cnt_next   = '0;
        end
      end
      S_START: begin
        if (cnt_reg == HALF_M1) begin
          if (rxs_reg) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_DATA;
            cnt_next   = '0;
            bit_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_reg == PERIOD_M1) begin
          cnt_next   = '0;
          shift_next = {rxs_reg, shift_reg[7:1]};
          if (bit_reg == 3'd7) state_next = S_STOP;
          else                 bit_next   = bit_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_reg == PERIOD_M1) begin
          cnt_next = '0;
          if (rxs_reg) begin
            state_next = S_IDLE;
            for (int i = 0; i < BYTES; i++) begin
              if (lane_sel[i]) word_next[8*i +: 8] = shift_reg;
            end
            if (idx_reg == LAST_IDX) begin
              data_next  = word_next;
              valid_next = 1'b1;
              idx_next   = '0;
              word_next  = '0;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end else begin
            // Bad stop bit: drop the whole partial word and wait for the line to recover
            ferr_next  = 1'b1;
            idx_next   = '0;
            word_next  = '0;
            state_next = S_WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (rxs_reg) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Inter-byte timeout; a start edge in the expiry cycle takes priority
    if (state_reg == S_IDLE && idx_reg != '0 && rxs_reg) begin
      if (to_reg == TO_M1) begin
        tout_next = 1'b1;
        idx_next  = '0;
        word_next = '0;
        to_next   = '0;
      end else begin
        to_next = to_reg + 1'b1;
      end
    end else begin
      to_next = '0;
    end

    busy_next = (state_next != S_IDLE) || (idx_next != '0);
  end

  assign bus.data_out      = data_reg;
  assign bus.valid_out     = valid_reg;
  assign bus.busy_out      = busy_reg;
  assign bus.frame_err_out = ferr_reg;
  assign bus.timeout_out   = tout_reg;
endmodule

// File: tb/tb_deserializer.sv
// Randomized scoreboard bench for deserializer: a byte-level model predicts
// words, framing errors and timeouts; a monitor checks every output strobe.
module tb_deserializer;
  localparam int BYTES  = 4;
  localparam int BAUD   = 1_000_000;
  localparam int FREQ   = 10_000_000;
  localparam int TOB    = 20;
  localparam int PERIOD = FREQ / BAUD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  deserializer_if #(.BYTES(BYTES)) bus ();

  deserializer #(
    .BYTES(BYTES), .BAUD_RATE(BAUD), .INPUT_CLOCK_FREQ(FREQ), .TIMEOUT_BITS(TOB)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  part_q[$];
  logic [31:0] last_word = '0;
  logic [31:0] mon_word;
  int          exp_ferr = 0, exp_tout = 0;
  int          seen_ferr = 0, seen_tout = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Reference model: bytes accumulate until a full word, errors discard them
  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    logic [31:0] w;
    if (stop_ok) begin
      part_q.push_back(b);
      if (part_q.size() == BYTES) begin
        w = '0;
        for (int i = 0; i < BYTES; i++) w = w | (32'(part_q[i]) << (8 * i));
        exp_q.push_back(w);
        last_word = w;
        part_q.delete();
      end
    end else begin
      part_q.delete();
      exp_ferr++;
    end
  endtask

  task automatic model_long_idle();
    if (part_q.size() != 0) begin
      exp_tout++;
      part_q.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    logic [9:0] frame;
    model_byte(b, stop_ok);
    frame = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx_wire_in = frame[i];
      repeat (PERIOD) @(negedge clk);
    end
    bus.rx_wire_in = 1'b1;
    repeat (gap) @(negedge clk);
    $display("byte 0x%02h stop=%0d gap=%0d", b, stop_ok, gap);
  endtask

  task automatic glitch();
    bus.rx_wire_in = 1'b0;
    repeat (3) @(negedge clk);
    bus.rx_wire_in = 1'b1;
    repeat (12) @(negedge clk);
    $display("glitch 3 cycles");
  endtask

  task automatic long_idle(input int n);
    model_long_idle();
    repeat (n) @(negedge clk);
    $display("idle %0d cycles", n);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_errs"}, seen_ferr, exp_ferr);
    check({tag, "_timeouts"}, seen_tout, exp_tout);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every valid strobe
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_valid: got word 0x%08h, required no word", bus.data_out);
        end else begin
          mon_word = exp_q.pop_front();
          check("word", bus.data_out, mon_word);
          $display("word 0x%08h (required 0x%08h)", bus.data_out, mon_word);
        end
      end
      if (bus.frame_err_out) seen_ferr++;
      if (bus.timeout_out)   seen_tout++;
      if (bus.valid_out || bus.frame_err_out || bus.timeout_out)
        check("pulse_onehot",
              int'(bus.valid_out) + int'(bus.frame_err_out) + int'(bus.timeout_out), 1);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int r;
    bus.rx_wire_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", bus.data_out, 0);
    check("rst_valid", bus.valid_out, 0);
    check("rst_busy", bus.busy_out, 0);
    check("rst_ferr", bus.frame_err_out, 0);
    check("rst_tout", bus.timeout_out, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: basic word
    send_byte(8'hEF, 1, 3);
    send_byte(8'hBE, 1, 3);
    send_byte(8'hAD, 1, 3);
    send_byte(8'hDE, 1, 0);
    check("t1_busy_after", bus.busy_out, 0);
    check("t1_data", bus.data_out, 32'hDEADBEEF);
    check_counts("t1");

    // 2: short glitch is a false start
    glitch();
    check("t2_busy", bus.busy_out, 0);
    check("t2_data", bus.data_out, last_word);
    check_counts("t2");

    // 3: framing error discards partial word
    send_byte(8'h11, 1, 2);
    send_byte(8'h55, 0, 6);
    check("t3_data_held", bus.data_out, last_word);
    check("t3_busy", bus.busy_out, 0);
    send_byte(8'h04, 1, 2);
    send_byte(8'h03, 1, 2);
    send_byte(8'h02, 1, 2);
    send_byte(8'h01, 1, 2);
    check("t3_data", bus.data_out, 32'h01020304);
    check_counts("t3");

    // 4: timeout; stop sample is 2 cycles before the end of the stop slot
    send_byte(8'hAA, 1, 2);
    send_byte(8'hBB, 1, 0);
    model_long_idle();
    c = 0;
    while (!bus.timeout_out && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("t4_timeout_latency", c, TOB * PERIOD - 2);
    check("t4_busy", bus.busy_out, 0);
    check("t4_data_held", bus.data_out, 32'h01020304);
    repeat (5) @(negedge clk);
    send_byte(8'h01, 1, 1);
    send_byte(8'h02, 1, 1);
    send_byte(8'h03, 1, 1);
    send_byte(8'h04, 1, 1);
    check("t4_data", bus.data_out, 32'h04030201);
    check_counts("t4");

    // 5: reset mid-word
    send_byte(8'h9A, 1, 2);
    send_byte(8'hBC, 1, 2);
    rst_n = 1'b0;
    @(negedge clk);
    part_q.delete();
    last_word = '0;
    check("t5_rst_data", bus.data_out, 0);
    check("t5_rst_busy", bus.busy_out, 0);
    check("t5_rst_pulses", {bus.valid_out, bus.frame_err_out, bus.timeout_out}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h78, 1, 2);
    send_byte(8'h56, 1, 2);
    send_byte(8'h34, 1, 2);
    send_byte(8'h12, 1, 2);
    check("t5_data", bus.data_out, 32'h12345678);
    check_counts("t5");

    // 6: eight back-to-back bytes
    send_byte(8'hFF, 1, 0);
    send_byte(8'hFF, 1, 0);
    send_byte(8'h00, 1, 0);
    send_byte(8'h00, 1, 0);
    send_byte(8'h0D, 1, 0);
    send_byte(8'hF0, 1, 0);
    send_byte(8'hFE, 1, 0);
    send_byte(8'hCA, 1, 5);
    check("t6_data", bus.data_out, 32'hCAFEF00D);
    check_counts("t6");

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 13)      send_byte(8'($urandom_range(0, 255)), 1, int'($urandom_range(0, 30)));
      else if (r < 15) send_byte(8'($urandom_range(0, 255)), 0, int'($urandom_range(4, 20)));
      else if (r < 17) glitch();
      else             long_idle(250);
    end
    long_idle(250);
    check("rand_data", bus.data_out, last_word);
    check("rand_busy", bus.busy_out, 0);
    check_counts("rand");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the multi-byte UART serializer.
- Samples an asynchronous 8N1 UART line and reassembles BYTES consecutive bytes into one word, in the same byte order the serializer transmits (byte 0 = bits [7:0], sent first).
- Presents each complete word with a one-cycle valid strobe.
- Flags framing errors and stalled (timed-out) partial words.

Parameters:
- BYTES, 4, bytes per assembled word (≥1).
- BAUD_RATE, 9600, line bit rate in bits/s.
- INPUT_CLOCK_FREQ, 100_000_000, clk_in frequency in Hz.
- TIMEOUT_BITS, 20, idle bit periods allowed between bytes of one word before the partial word is discarded.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  synchronous, active-low reset.
- rx_wire_in  input  1  asynchronous UART line; idle high.
- data_out  output  8*BYTES  last complete word; held until the next word completes.
- valid_out  output  1  one-cycle pulse when data_out updates.
- busy_out  output  1  high while a byte or a partial word is in progress.
- frame_err_out  output  1  one-cycle pulse on a bad stop bit.
- timeout_out  output  1  one-cycle pulse when a partial word is discarded for inactivity.

Behaviour:
- Single clock. Reset is synchronous, active-low, and takes effect on the clk_in edge where rst_n_in=0.
- Reset values:
  - data_out=0, valid_out=0, busy_out=0, frame_err_out=0, timeout_out=0.
  - FSM=IDLE, byte index=0, all counters=0.
  - Both synchronizer flops=1 (idle line).
- Reset mid-byte or mid-word discards all partial data with no error pulse.
- Timing constants:
  - PERIOD = INPUT_CLOCK_FREQ/BAUD_RATE (integer divide). HALF = PERIOD/2.
  - Bit counter width is $clog2(PERIOD).
  - Timeout counter reaches TIMEOUT_BITS*PERIOD, with width sized to hold that value.
- rx_wire_in passes through a 2-flop synchronizer; all logic uses the synchronized value rxs.
- Bit FSM:
  - IDLE: rxs==0 → START, clear bit counter.
  - START: at count HALF-1, sample rxs.
    - rxs==1: false start → IDLE, no error, nothing stored.
    - rxs==0: → DATA, restart counter.
  - DATA: at count PERIOD-1, sample rxs into shift register, LSB first. After the 8th sample → STOP.
  - STOP: at count PERIOD-1 (mid stop bit), sample rxs.
    - rxs==1: byte good → IDLE.
    - rxs==0: frame_err_out pulses next cycle, partial word and index cleared → WAIT_HIGH.
  - WAIT_HIGH: stay until rxs==1, then → IDLE. This prevents a low line re-triggering START.
- Word assembly:
  - Each good byte is written to word[8*index +: 8].
  - If index < BYTES-1: index increments.
  - If index == BYTES-1: data_out takes the full word including this byte, valid_out pulses, index returns to 0.
  - valid_out asserts exactly one cycle after the stop-bit sample cycle.
  - BYTES=1: every good byte produces a valid_out pulse.
- Back-to-back bytes (start edge immediately after stop mid-sample) are received with no gap.
- Timeout:
  - Counter runs only while FSM==IDLE and index≠0. It clears on leaving IDLE or when index==0.
  - On reaching TIMEOUT_BITS*PERIOD: timeout_out pulses, index=0, partial discarded.
  - If start detection and timeout expiry occur in the same cycle, the start wins and there is no timeout.
- busy_out is registered: busy_out = (FSM≠IDLE) || (index≠0). It returns to 0 the cycle after word completion, frame error (once WAIT_HIGH exits), or timeout.
- Output pulses never coincide: valid_out, frame_err_out and timeout_out are mutually exclusive per cycle.
- data_out is unchanged by errors, timeouts and false starts.

Test Plan:
Bench parameters: INPUT_CLOCK_FREQ=10_000_000, BAUD_RATE=1_000_000 (PERIOD=10), BYTES=4, TIMEOUT_BITS=20.
1. Send bytes 0xEF,0xBE,0xAD,0xDE as 8N1 → data_out=0xDEADBEEF, valid_out high exactly 1 cycle, busy_out 0 afterwards, no error pulses.
2. Drive rx low for 3 cycles, then high (glitch shorter than HALF) → no state change, busy_out stays 0, no pulses.
3. Send 0x11, then 0x55 with stop bit=0 → one frame_err_out pulse, data_out unchanged. Then send 0x04,0x03,0x02,0x01 → data_out=0x01020304, one valid_out.
4. Send 0xAA,0xBB, then idle 200+ cycles → one timeout_out pulse at 200 idle cycles, busy_out→0. Then send 4 bytes 0x01..0x04 → data_out=0x04030201.
5. Send 2 bytes, pulse rst_n_in low for 1 cycle → all outputs 0. Then send 0x78,0x56,0x34,0x12 → data_out=0x12345678.
6. Send 8 bytes back-to-back (next start bit directly after each stop bit) encoding 0x0000FFFF then 0xCAFEF00D → two valid_out pulses with those words in order, no errors.
